// File: rtl/fpu_sched.sv
// fpu_sched: latency-scheduled FP add/mul/compare with one shared writeback port; FPU_DP_EN adds the DP units.
package fpu_sched_pkg;
    typedef enum logic [3:0] {
        SP_ADD = 4'd0, SP_SUB = 4'd1, SP_MUL = 4'd2, FP_NOP = 4'd3,
        SP_CMP_LT = 4'd4, SP_CMP_LE = 4'd5, SP_CMP_EQ = 4'd6,
        DP_ADD = 4'd8, DP_SUB = 4'd9, DP_MUL = 4'd10,
        DP_CMP_LT = 4'd12, DP_CMP_LE = 4'd13, DP_CMP_EQ = 4'd14
    } opcode_t;
endpackage

module fp_delay #(parameter int W = 32, parameter int LAT = 1) (
    input  logic         clk,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] p [LAT];
    always_ff @(posedge clk) begin
        p[0] <= en ? d : '0;
        for (int i = 1; i < LAT; i++) p[i] <= p[i-1];
    end
    assign q = p[LAT-1];
endmodule

module fp_add #(parameter int W = 32, parameter int LAT = 3) (
    input  logic         clk,
    input  logic         en,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    localparam int E = W == 32 ? 8 : 11, M = W - 1 - E, G = 3, N = M + 2 + G;
    logic [W-1:0] bb, x, z, r;
    logic [N-1:0] mx, mz, sum, norm;
    int p, e;
    always_comb begin
        bb = {b[W-1] ^ sub, b[W-2:0]};
        x = a[W-2:0] >= bb[W-2:0] ? a : bb;
        z = a[W-2:0] >= bb[W-2:0] ? bb : a;
        mx = {1'b0, |x[W-2:M], x[M-1:0], {G{1'b0}}};
        mz = {1'b0, |z[W-2:M], z[M-1:0], {G{1'b0}}} >> (x[W-2:M] - z[W-2:M]);
        sum = x[W-1] == z[W-1] ? mx + mz : mx - mz;
        p = 0;
        for (int i = 0; i < N; i++) if (sum[i]) p = i;
        e = int'(x[W-2:M]) + p - (M + G);
        norm = p >= M + G ? sum >> (p - M - G) : sum << (M + G - p);
        r = (sum == '0 || e <= 0) ? '0 : {x[W-1], E'(e), M'(norm >> G)};
    end
    fp_delay #(.W(W), .LAT(LAT)) u_dly (.clk(clk), .en(en), .d(r), .q(y));
endmodule

module fp_mul #(parameter int W = 32, parameter int LAT = 4) (
    input  logic         clk,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    localparam int E = W == 32 ? 8 : 11, M = W - 1 - E, BIAS = (1 << (E - 1)) - 1;
    logic [2*M+1:0] prod;
    logic [M-1:0] mant;
    logic [W-1:0] r;
    int e;
    always_comb begin
        prod = {{(M+1){1'b0}}, 1'b1, a[M-1:0]} * {{(M+1){1'b0}}, 1'b1, b[M-1:0]};
        e = int'(a[W-2:M]) + int'(b[W-2:M]) - BIAS + (prod[2*M+1] ? 1 : 0);
        mant = prod[2*M+1] ? M'(prod >> (M + 1)) : M'(prod >> M);
        r = (a[W-2:M] == '0 || b[W-2:M] == '0 || e <= 0) ? '0 : {a[W-1] ^ b[W-1], E'(e), mant};
    end
    fp_delay #(.W(W), .LAT(LAT)) u_dly (.clk(clk), .en(en), .d(r), .q(y));
endmodule

module fp_compare #(parameter int W = 32, parameter int D = 1) (
    input  logic         clk,
    input  logic         en,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         y
);
    logic [W-1:0] ka, kb;
    logic both_zero, lt, eq, r;
    always_comb begin
        ka = a[W-1] ? ~a : {1'b1, a[W-2:0]};
        kb = b[W-1] ? ~b : {1'b1, b[W-2:0]};
        both_zero = ~|{a[W-2:0], b[W-2:0]};
        eq = both_zero || a == b;
        lt = !both_zero && ka < kb;
        r = op == 2'd2 ? eq : op == 2'd1 ? (lt || eq) : lt;
    end
    fp_delay #(.W(1), .LAT(D)) u_dly (.clk(clk), .en(en), .d(r), .q(y));
endmodule

module fpu_sched import fpu_sched_pkg::*; #(
    parameter int LG_PRF_WIDTH = 4,
    parameter int LG_ROB_WIDTH = 4,
    parameter int LG_FCR_WIDTH = 4,
    parameter int ADD_LAT = 3,
    parameter int MUL_LAT = 4,
    parameter int CMP_LAT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    start,
    output logic                    ready,
    input  opcode_t                 opcode,
    input  logic [63:0]             pc,
    input  logic [63:0]             src_a,
    input  logic [63:0]             src_b,
    input  logic [7:0]              src_fcr,
    input  logic [2:0]              fcr_sel,
    input  logic [LG_ROB_WIDTH-1:0] rob_ptr_in,
    input  logic [LG_PRF_WIDTH-1:0] dst_ptr_in,
    input  logic [LG_FCR_WIDTH-1:0] fcr_ptr_in,
    output logic                    val,
    output logic                    cmp_val,
    output logic                    unimp,
    output logic [63:0]             y,
    output logic [LG_ROB_WIDTH-1:0] rob_ptr_out,
    output logic [LG_PRF_WIDTH-1:0] dst_ptr_out,
    output logic [LG_FCR_WIDTH-1:0] fcr_ptr_out,
    output logic                    busy
);
    localparam int MAX_LAT = ADD_LAT > MUL_LAT ? (ADD_LAT > CMP_LAT ? ADD_LAT : CMP_LAT)
                                               : (MUL_LAT > CMP_LAT ? MUL_LAT : CMP_LAT);
    typedef struct packed {
        opcode_t                 op;
        logic [LG_ROB_WIDTH-1:0] rob;
        logic [LG_PRF_WIDTH-1:0] dst;
        logic [LG_FCR_WIDTH-1:0] fcr;
        logic [2:0]              sel;
        logic [7:0]              src_fcr;
    } meta_t;
    meta_t meta [MAX_LAT];
    meta_t m0;
    logic [MAX_LAT:0] s, ins;
    logic is_add, is_mul, is_cmp, hit, accept, cr, unused;
    logic [31:0] add_sp, mul_sp;
    logic [63:0] arith;
    logic [7:0] fcr_new;
    logic cmp_sp;
    int lat;
    always_comb begin
        is_add = opcode[2:1] == 2'b00;
        is_mul = opcode[2:0] == 3'b010;
        is_cmp = opcode[2] && opcode[1:0] != 2'b11;
`ifdef FPU_DP_EN
        lat = is_add ? ADD_LAT : is_mul ? MUL_LAT : CMP_LAT;
`else
        lat = opcode[3] ? CMP_LAT : is_add ? ADD_LAT : is_mul ? MUL_LAT : CMP_LAT;
`endif
        hit = 1'b0;
        for (int i = 0; i <= MAX_LAT; i++) hit |= s[i] && lat == i;
        ready = (is_add || is_mul || is_cmp) && !hit && !flush && !reset;
        accept = start && ready;
        ins = '0;
        for (int i = 0; i < MAX_LAT; i++) ins[i] = accept && lat == i + 1;
    end
    always_ff @(posedge clk) begin
        s <= (reset || flush) ? '0 : {1'b0, s[MAX_LAT:1]} | ins;
        for (int i = 0; i < MAX_LAT - 1; i++) meta[i] <= meta[i+1];
        for (int i = 0; i < MAX_LAT; i++)
            if (accept && lat == i + 1) meta[i] <= '{opcode, rob_ptr_in, dst_ptr_in, fcr_ptr_in, fcr_sel, src_fcr};
    end
    assign m0 = meta[0];
    fp_add #(.W(32), .LAT(ADD_LAT)) u_add_sp (.clk(clk), .en(accept && is_add && !opcode[3]), .sub(opcode[0]),
        .a(src_a[31:0]), .b(src_b[31:0]), .y(add_sp));
    fp_mul #(.W(32), .LAT(MUL_LAT)) u_mul_sp (.clk(clk), .en(accept && is_mul && !opcode[3]),
        .a(src_a[31:0]), .b(src_b[31:0]), .y(mul_sp));
    fp_compare #(.W(32), .D(CMP_LAT)) u_cmp_sp (.clk(clk), .en(accept && is_cmp && !opcode[3]), .op(opcode[1:0]),
        .a(src_a[31:0]), .b(src_b[31:0]), .y(cmp_sp));
`ifdef FPU_DP_EN
    logic [63:0] add_dp, mul_dp;
    logic cmp_dp;
    fp_add #(.W(64), .LAT(ADD_LAT)) u_add_dp (.clk(clk), .en(accept && is_add && opcode[3]), .sub(opcode[0]),
        .a(src_a), .b(src_b), .y(add_dp));
    fp_mul #(.W(64), .LAT(MUL_LAT)) u_mul_dp (.clk(clk), .en(accept && is_mul && opcode[3]),
        .a(src_a), .b(src_b), .y(mul_dp));
    fp_compare #(.W(64), .D(CMP_LAT)) u_cmp_dp (.clk(clk), .en(accept && is_cmp && opcode[3]), .op(opcode[1:0]),
        .a(src_a), .b(src_b), .y(cmp_dp));
    assign arith = m0.op[3] ? (m0.op[1] ? mul_dp : add_dp) : {32'd0, m0.op[1] ? mul_sp : add_sp};
    assign cr = m0.op[3] ? cmp_dp : cmp_sp;
    assign unused = ^{pc, m0.op[0]};
`else
    assign arith = {32'd0, m0.op[1] ? mul_sp : add_sp};
    assign cr = cmp_sp;
    assign unused = ^{pc, src_a[63:32], src_b[63:32], m0.op[0]};
`endif
    always_comb begin
        fcr_new = m0.src_fcr;
        fcr_new[m0.sel] = cr;
        val = s[0] && !m0.op[2];
        cmp_val = s[0] && m0.op[2];
`ifdef FPU_DP_EN
        unimp = 1'b0;
        y = !s[0] ? '0 : m0.op[2] ? {56'd0, fcr_new} : arith;
`else
        unimp = s[0] && m0.op[3];
        y = !s[0] ? '0 : m0.op[2] ? {56'd0, m0.op[3] ? m0.src_fcr : fcr_new} : m0.op[3] ? '0 : arith;
`endif
        rob_ptr_out = s[0] ? m0.rob : '0;
        dst_ptr_out = s[0] ? m0.dst : '0;
        fcr_ptr_out = s[0] ? m0.fcr : '0;
        busy = |s;
    end
endmodule
